// File: rtl/mem_responder.sv
// Single-port word memory slave with fixed wait states and byte-enabled writes; out-of-range addresses end in err_o.
// Latency: the ack_o/err_o pulse comes WAIT_STATES+1 cycles after acceptance; dropping cyc_i/stb_i while waiting abandons the request.
module mem_responder #(
    parameter int DATA_SIZE   = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [DATA_SIZE/8-1:0] sel_i,
    input  logic [DATA_SIZE-1:0]   addr_i,
    input  logic [DATA_SIZE-1:0]   dat_i,
    output logic [DATA_SIZE-1:0]   dat_o,
    output logic                   ack_o,
    output logic                   err_o
);

    localparam int NB    = DATA_SIZE / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI    = OFF_W + IDX_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   we_q, oor_q, ack_q, err_q;
    logic [NB-1:0]          sel_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_SIZE-1:0]   wdat_q, rdat_q;
    logic [DATA_SIZE-1:0]   mem_q [DEPTH];

    logic                   req, latch, fire, in_idle;
    logic                   oor_in, eff_we, eff_oor;
    logic [IDX_W-1:0]       idx_in, eff_idx;
    logic [NB-1:0]          eff_sel;
    logic [DATA_SIZE-1:0]   eff_dat;
    logic                   unused_addr_bits;

    assign req              = cyc_i & stb_i;
    assign idx_in           = addr_i[OFF_W +: IDX_W];
    assign oor_in           = |(addr_i >> HI);
    assign unused_addr_bits = ^addr_i[OFF_W-1:0];

    // With no wait states the access fires on the acceptance edge itself, so
    // the live inputs stand in for the latched copies while in IDLE.
    assign in_idle = (state_q == IDLE);
    assign eff_we  = in_idle ? we_i   : we_q;
    assign eff_sel = in_idle ? sel_i  : sel_q;
    assign eff_idx = in_idle ? idx_in : idx_q;
    assign eff_dat = in_idle ? dat_i  : wdat_q;
    assign eff_oor = in_idle ? oor_in : oor_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    latch   = 1'b1;
                    cnt_d   = 3'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                    fire    = (WAIT_STATES == 0);
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= fire & ~eff_oor;
            err_q   <= fire & eff_oor;
            if (latch) begin
                we_q   <= we_i;
                sel_q  <= sel_i;
                idx_q  <= idx_in;
                wdat_q <= dat_i;
                oor_q  <= oor_in;
            end
            if (fire && !eff_we && !eff_oor)
                rdat_q <= mem_q[eff_idx];
        end
    end

    // Storage is not reset; the reset term keeps a write from landing while reset is held.
    always_ff @(posedge clock) begin
        if (reset && fire && eff_we && !eff_oor) begin
            for (int k = 0; k < NB; k++) begin
                if (eff_sel[k])
                    mem_q[eff_idx][8*k +: 8] <= eff_dat[8*k +: 8];
            end
        end
    end

    assign dat_o = rdat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_STATES 1, 3, 0) share clock and reset.
module tb_mem_responder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  cyc, stb, we;
    logic [7:0]  sel  [3];
    logic [63:0] addr [3];
    logic [63:0] dati [3];
    wire  [2:0]  ack, err;
    wire  [63:0] dato [3];

    int n_cmp = 0;
    int n_bad = 0;

    mem_responder #(.DATA_SIZE(64), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(reset), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .sel_i(sel[0]), .addr_i(addr[0]), .dat_i(dati[0]), .dat_o(dato[0]),
        .ack_o(ack[0]), .err_o(err[0]));

    mem_responder #(.DATA_SIZE(64), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .sel_i(sel[1]), .addr_i(addr[1]), .dat_i(dati[1]), .dat_o(dato[1]),
        .ack_o(ack[1]), .err_o(err[1]));

    mem_responder #(.DATA_SIZE(64), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
        .sel_i(sel[2]), .addr_i(addr[2]), .dat_i(dati[2]), .dat_o(dato[2]),
        .ack_o(ack[2]), .err_o(err[2]));

    function automatic int ws_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge with the target instance idle.
    task automatic txn(input int u, input logic w, input logic [7:0] s,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic ea, input logic ee, input logic [63:0] ed,
                       input string nm);
        int ws;
        ws = ws_of(u);
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w;
        sel[u] = s; addr[u] = a; dati[u] = d;
        for (int c = 0; c <= ws; c++) begin
            @(negedge clock);
            if (c < ws) chk({nm, " early resp"}, {62'd0, ack[u], err[u]}, 64'd0);
        end
        chk({nm, " ack"}, 64'(ack[u]), 64'(ea));
        chk({nm, " err"}, 64'(err[u]), 64'(ee));
        chk({nm, " dat_o"}, dato[u], ed);
        cyc[u] = 1'b0; stb[u] = 1'b0;
        @(negedge clock);
        chk({nm, " pulse width"}, {62'd0, ack[u], err[u]}, 64'd0);
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  s;
        logic [63:0] a;
        logic [63:0] d;
        logic        ea;
        logic        ee;
        logic [63:0] ed;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        string nm;
        tbl[0]  = '{1'b1, 8'hFF, 64'h10,  64'h1122334455667788, 1'b1, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 8'hFF, 64'h10,  64'h0,                1'b1, 1'b0, 64'h1122334455667788};
        tbl[2]  = '{1'b1, 8'h0F, 64'h10,  64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0, 64'h1122334455667788};
        tbl[3]  = '{1'b0, 8'hFF, 64'h10,  64'h0,                1'b1, 1'b0, 64'h11223344AAAAAAAA};
        tbl[4]  = '{1'b0, 8'hFF, 64'h800, 64'h0,                1'b0, 1'b1, 64'h11223344AAAAAAAA};
        tbl[5]  = '{1'b1, 8'h00, 64'h10,  64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 64'h11223344AAAAAAAA};
        tbl[6]  = '{1'b0, 8'h00, 64'h10,  64'h0,                1'b1, 1'b0, 64'h11223344AAAAAAAA};
        tbl[7]  = '{1'b1, 8'hFF, 64'h7FF, 64'h0123456789ABCDEF, 1'b1, 1'b0, 64'h11223344AAAAAAAA};
        tbl[8]  = '{1'b0, 8'hFF, 64'h7F8, 64'h0,                1'b1, 1'b0, 64'h0123456789ABCDEF};
        tbl[9]  = '{1'b1, 8'h81, 64'h7F8, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 64'h0123456789ABCDEF};
        tbl[10] = '{1'b0, 8'hFF, 64'h7FC, 64'h0,                1'b1, 1'b0, 64'hFF23456789ABCDFF};
        tbl[11] = '{1'b1, 8'hFF, 64'h810, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b1, 64'hFF23456789ABCDFF};
        tbl[12] = '{1'b0, 8'hFF, 64'h17,  64'h0,                1'b1, 1'b0, 64'h11223344AAAAAAAA};

        cyc = '0; stb = '0; we = '0;
        for (int u = 0; u < 3; u++) begin
            sel[u] = '0; addr[u] = '0; dati[u] = '0;
        end

        @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset ack u%0d", u), 64'(ack[u]), 64'd0);
            chk($sformatf("reset err u%0d", u), 64'(err[u]), 64'd0);
            chk($sformatf("reset dat_o u%0d", u), dato[u], 64'd0);
        end

        // Release and immediately offer the first request.
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            nm = $sformatf("vec%0d", i);
            txn(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].ea, tbl[i].ee, tbl[i].ed, nm);
        end

        // Zero wait states with the request held: responses alternate 1,0.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 8'hFF;
        addr[2] = 64'h40; dati[2] = 64'h0F0E0D0C0B0A0908;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk($sformatf("ws0 ack cyc%0d", c), 64'(ack[2]), (c % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("ws0 err cyc%0d", c), 64'(err[2]), 64'd0);
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clock);
        txn(2, 1'b0, 8'hFF, 64'h40, 64'h0, 1'b1, 1'b0, 64'h0F0E0D0C0B0A0908, "ws0 readback");

        txn(1, 1'b1, 8'hFF, 64'h20, 64'h5555555555555555, 1'b1, 1'b0, 64'h0, "ws3 wr");
        txn(1, 1'b0, 8'hFF, 64'h20, 64'h0, 1'b1, 1'b0, 64'h5555555555555555, "ws3 rd");

        // Abort: strobe dropped in the middle of the wait.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
        addr[1] = 64'h20; dati[1] = 64'h9999999999999999;
        @(negedge clock);
        chk("abort in wait", {62'd0, ack[1], err[1]}, 64'd0);
        stb[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("abort quiet %0d", c), {62'd0, ack[1], err[1]}, 64'd0);
        end
        cyc[1] = 1'b0;
        txn(1, 1'b0, 8'hFF, 64'h20, 64'h0, 1'b1, 1'b0, 64'h5555555555555555, "abort old data");

        // Request inputs scrambled during the wait must not matter.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
        addr[1] = 64'h20; dati[1] = 64'h1111111111111111;
        @(negedge clock);
        we[1] = 1'b0; sel[1] = 8'h00; addr[1] = 64'h28; dati[1] = 64'h2222222222222222;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c < 3) chk("latched early resp", {62'd0, ack[1], err[1]}, 64'd0);
        end
        chk("latched ack", 64'(ack[1]), 64'd1);
        chk("latched dat_o", dato[1], 64'h5555555555555555);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clock);
        txn(1, 1'b0, 8'hFF, 64'h20, 64'h0, 1'b1, 1'b0, 64'h1111111111111111, "latched readback");

        // Reset pulsed during the wait of a write.
        txn(1, 1'b1, 8'hFF, 64'h30, 64'h7777777777777777, 1'b1, 1'b0, 64'h1111111111111111, "pre-rst wr");
        txn(1, 1'b0, 8'hFF, 64'h30, 64'h0, 1'b1, 1'b0, 64'h7777777777777777, "pre-rst rd");
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
        addr[1] = 64'h30; dati[1] = 64'h3333333333333333;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst ack", 64'(ack[1]), 64'd0);
        chk("rst err", 64'(err[1]), 64'd0);
        chk("rst dat_o async", dato[1], 64'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk($sformatf("post-rst quiet %0d", c), {62'd0, ack[1], err[1]}, 64'd0);
        end
        txn(1, 1'b0, 8'hFF, 64'h30, 64'h0, 1'b1, 1'b0, 64'h7777777777777777, "post-rst mem");
        txn(0, 1'b0, 8'hFF, 64'h10, 64'h0, 1'b1, 1'b0, 64'h11223344AAAAAAAA, "mem survives rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
